// File: rtl/load_store_unit_if.sv
// Memory bus between the load/store unit (master) and the data memory (slave).
// One request channel with a valid/ready handshake, plus a valid-only load response.
interface load_store_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req_valid_out;
  logic             req_ready_in;
  logic [WIDTH-1:0] req_addr_out;
  logic             req_we_out;
  logic [3:0]       req_be_out;
  logic [WIDTH-1:0] req_wdata_out;
  logic             rsp_valid_in;
  logic [WIDTH-1:0] rsp_rdata_in;

  modport master (
    output req_valid_out, req_addr_out, req_we_out, req_be_out, req_wdata_out,
    input  req_ready_in, rsp_valid_in, rsp_rdata_in
  );

  modport slave (
    input  req_valid_out, req_addr_out, req_we_out, req_be_out, req_wdata_out,
    output req_ready_in, rsp_valid_in, rsp_rdata_in
  );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: validates the access, issues one bus request,
// stalls the pipeline until it completes, and sign/zero-extends load data.
module load_store_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned INDEX = 5
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             mem_read_in,
  input  logic             mem_write_in,
  input  logic [2:0]       funct3_in,
  input  logic [WIDTH-1:0] addr_in,
  input  logic [WIDTH-1:0] wdata_in,
  input  logic [INDEX-1:0] rd_in,
  load_store_unit_if.master bus,
  output logic [WIDTH-1:0] load_data_out,
  output logic [INDEX-1:0] rd_out,
  output logic             stall_out,
  output logic             err_out
);

  localparam int unsigned BYTES = WIDTH / 8;
  localparam int unsigned HALVES = WIDTH / 16;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e           state_q;
  logic             req_valid_q;
  logic             req_we_q;
  logic [3:0]       req_be_q;
  logic [WIDTH-1:0] req_addr_q;
  logic [WIDTH-1:0] req_wdata_q;
  logic [1:0]       off_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [INDEX-1:0] rd_q;
  logic [WIDTH-1:0] load_data_q;
  logic [INDEX-1:0] rd_out_q;

  logic             access_c;
  logic             f3_ok_c;
  logic             align_ok_c;
  logic             illegal_c;
  logic             start_c;
  logic [3:0]       be_c;
  logic [WIDTH-1:0] wdata_c;
  logic [WIDTH-1:0] shifted_c;
  logic [WIDTH-1:0] load_c;

  // Access decode: legality, byte enables and lane-replicated store data
  always_comb begin
    access_c   = mem_read_in | mem_write_in;
    f3_ok_c    = 1'b0;
    align_ok_c = 1'b0;
    be_c       = 4'b0000;
    wdata_c    = wdata_in;
    if (mem_read_in) begin
      f3_ok_c = funct3_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end else begin
      f3_ok_c = funct3_in inside {3'b000, 3'b001, 3'b010};
    end
    case (funct3_in[1:0])
      2'b00: begin
        align_ok_c = 1'b1;
        be_c       = 4'b0001 << addr_in[1:0];
        wdata_c    = {BYTES{wdata_in[7:0]}};
      end
      2'b01: begin
        align_ok_c = ~addr_in[0];
        be_c       = 4'b0011 << addr_in[1:0];
        wdata_c    = {HALVES{wdata_in[15:0]}};
      end
      2'b10: begin
        align_ok_c = (addr_in[1:0] == 2'b00);
        be_c       = 4'b1111;
        wdata_c    = wdata_in;
      end
      default: begin
        align_ok_c = 1'b0;
        be_c       = 4'b0000;
        wdata_c    = wdata_in;
      end
    endcase
    illegal_c = access_c & ((mem_read_in & mem_write_in) | ~f3_ok_c | ~align_ok_c);
    start_c   = access_c & ~illegal_c;
  end

  // Load extraction from the response word using the offset captured at issue
  always_comb begin
    shifted_c = bus.rsp_rdata_in >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_c = {{(WIDTH-8){shifted_c[7] & ~uns_q}}, shifted_c[7:0]};
      2'b01:   load_c = {{(WIDTH-16){shifted_c[15] & ~uns_q}}, shifted_c[15:0]};
      default: load_c = shifted_c;
    endcase
  end

  // Access sequencer; request fields are frozen from issue until acceptance
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_be_q    <= 4'b0000;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      off_q       <= 2'b00;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      rd_q        <= '0;
      load_data_q <= '0;
      rd_out_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_c) begin
            state_q     <= REQ;
            req_valid_q <= 1'b1;
            req_addr_q  <= {addr_in[WIDTH-1:2], 2'b00};
            req_we_q    <= mem_write_in;
            req_be_q    <= be_c;
            req_wdata_q <= wdata_c;
            off_q       <= addr_in[1:0];
            size_q      <= funct3_in[1:0];
            uns_q       <= funct3_in[2];
            rd_q        <= rd_in;
          end
        end
        REQ: begin
          if (bus.req_ready_in) begin
            req_valid_q <= 1'b0;
            state_q     <= req_we_q ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (bus.rsp_valid_in) begin
            load_data_q <= load_c;
            rd_out_q    <= rd_q;
            state_q     <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Stall and error are combinational so the pipeline freezes in the issuing cycle
  assign stall_out = ((state_q == IDLE) & start_c) | (state_q == REQ) | (state_q == WAIT);
  assign err_out   = (state_q == IDLE) & illegal_c;

  assign bus.req_valid_out = req_valid_q;
  assign bus.req_addr_out  = req_addr_q;
  assign bus.req_we_out    = req_we_q;
  assign bus.req_be_out    = req_be_q;
  assign bus.req_wdata_out = req_wdata_q;
  assign load_data_out     = load_data_q;
  assign rd_out            = rd_out_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit: a driver issues accesses, a bus
// slave model answers them, and a monitor compares requests and load results.
module tb_load_store_unit;

  logic        clk_in;
  logic        rst_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic [4:0]  rd_in;
  logic [31:0] load_data_out;
  logic [4:0]  rd_out;
  logic        stall_out;
  logic        err_out;

  load_store_unit_if #(.WIDTH(32)) bus ();

  load_store_unit #(.WIDTH(32), .INDEX(5)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .mem_read_in   (mem_read_in),
    .mem_write_in  (mem_write_in),
    .funct3_in     (funct3_in),
    .addr_in       (addr_in),
    .wdata_in      (wdata_in),
    .rd_in         (rd_in),
    .bus           (bus),
    .load_data_out (load_data_out),
    .rd_out        (rd_out),
    .stall_out     (stall_out),
    .err_out       (err_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Slave-model controls set by the driver
  int          ready_cnt = 0;
  int          rsp_delay = 0;
  int          rsp_cnt = 0;
  logic [31:0] cur_rdata = 32'h0;
  bit          pending = 1'b0;
  bit          orphan_rsp = 1'b0;
  bit          genuine = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, written from the access rules in bytes
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_legal(input bit r, input bit w, input logic [2:0] f3, input logic [31:0] a);
    if (r == w) return 1'b0;
    if (r && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    if (w && f3 > 3'd2) return 1'b0;
    return (a % nbytes(f3)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int m;
    m = ((1 << nbytes(f3)) - 1) << (a % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] res;
    int nb;
    nb = nbytes(f3);
    res = 32'h0;
    for (int lane = 0; lane < 4; lane++) begin
      res[lane*8 +: 8] = 8'(wd >> (8 * (lane % nb)));
    end
    return res;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
    logic [31:0] v;
    logic [31:0] mask;
    int nb;
    nb = nbytes(f3);
    v = word >> (8 * (a % 4));
    if (nb < 4) begin
      mask = 32'((64'd1 << (8 * nb)) - 64'd1);
      v = v & mask;
      if (!f3[2] && v[8*nb-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // Bus slave: delayed ready, delayed load response, stray responses when idle
  initial begin
    bus.req_ready_in = 1'b0;
    bus.rsp_valid_in = 1'b0;
    bus.rsp_rdata_in = 32'h0;
    forever begin
      @(negedge clk_in);
      bus.req_ready_in = 1'b0;
      bus.rsp_valid_in = 1'b0;
      genuine = 1'b0;
      if (pending) begin
        if (rsp_cnt == 0) begin
          bus.rsp_valid_in = 1'b1;
          bus.rsp_rdata_in = cur_rdata;
          genuine = !orphan_rsp;
          pending = 1'b0;
        end else begin
          rsp_cnt--;
        end
      end else if (bus.req_valid_out === 1'b1) begin
        if (ready_cnt == 0) begin
          bus.req_ready_in = 1'b1;
          if (!bus.req_we_out) begin
            pending = 1'b1;
            rsp_cnt = rsp_delay;
          end
        end else begin
          ready_cnt--;
        end
      end else if ($urandom_range(3) == 0) begin
        bus.rsp_valid_in = 1'b1;
        bus.rsp_rdata_in = $urandom;
      end
    end
  end

  // Monitor: request fields against the scoreboard, load result and its hold
  initial begin
    bit   prev_rst;
    bit   chk_rsp;
    logic [31:0] m_ld;
    logic [4:0]  m_rd;
    rsp_t e;
    req_t q;
    prev_rst = 1'b1;
    chk_rsp = 1'b0;
    m_ld = 32'h0;
    m_rd = 5'h0;
    forever begin
      @(negedge clk_in);
      #1;
      if (prev_rst) begin
        m_ld = 32'h0;
        m_rd = 5'h0;
      end else if (chk_rsp) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_unexpected", 32'h1, 32'h0);
        end else begin
          e = rsp_q.pop_front();
          m_ld = e.data;
          m_rd = e.rd;
        end
      end
      chk("load_data", load_data_out, m_ld);
      chk("rd_out", 32'(rd_out), 32'(m_rd));
      if (bus.req_valid_out === 1'b1) begin
        if (req_q.size() == 0) begin
          chk("req_unexpected", 32'h1, 32'h0);
        end else begin
          q = req_q[0];
          chk("req_addr", bus.req_addr_out, q.addr);
          chk("req_we", 32'(bus.req_we_out), 32'(q.we));
          chk("req_be", 32'(bus.req_be_out), 32'(q.be));
          if (q.we) chk("req_wdata", bus.req_wdata_out, q.wdata);
          if (bus.req_ready_in) void'(req_q.pop_front());
        end
      end
      chk_rsp = bus.rsp_valid_in && genuine && !rst_in;
      prev_rst = rst_in;
    end
  end

  // One MEM-stage access, held until the unit releases the stall
  task automatic do_access(input bit r, input bit w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [4:0] rd,
                           input int rdy_d, input int rsp_d, input logic [31:0] rdata);
    bit legal;
    int cnt;
    @(negedge clk_in);
    mem_read_in = r;
    mem_write_in = w;
    funct3_in = f3;
    addr_in = a;
    wdata_in = wd;
    rd_in = rd;
    ready_cnt = rdy_d;
    rsp_delay = rsp_d;
    cur_rdata = rdata;
    legal = m_legal(r, w, f3, a);
    if (legal) begin
      req_q.push_back('{addr: {a[31:2], 2'b00}, we: w, be: m_be(f3, a), wdata: m_wdata(f3, wd)});
      if (r) rsp_q.push_back('{data: m_load(f3, a, rdata), rd: rd});
    end
    #1;
    chk("err_idle", 32'(err_out), 32'((r | w) && !legal));
    chk("stall_idle", 32'(stall_out), 32'(legal));
    if (!legal) begin
      @(negedge clk_in);
      #1;
      chk("no_req", 32'(bus.req_valid_out), 32'h0);
    end else begin
      cnt = 1;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk_in);
        #1;
        if (stall_out === 1'b1) cnt++;
        else break;
      end
      chk("stall_cycles", 32'(cnt), r ? 32'(3 + rdy_d + rsp_d) : 32'(2 + rdy_d));
      chk("err_done", 32'(err_out), 32'h0);
    end
    mem_read_in = 1'b0;
    mem_write_in = 1'b0;
  endtask

  initial begin
    int sel;
    rst_in = 1'b1;
    mem_read_in = 1'b0;
    mem_write_in = 1'b0;
    funct3_in = 3'b0;
    addr_in = 32'h0;
    wdata_in = 32'h0;
    rd_in = 5'h0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    chk("rst_req_valid", 32'(bus.req_valid_out), 32'h0);
    chk("rst_req_we", 32'(bus.req_we_out), 32'h0);
    chk("rst_req_be", 32'(bus.req_be_out), 32'h0);
    chk("rst_req_addr", bus.req_addr_out, 32'h0);
    chk("rst_req_wdata", bus.req_wdata_out, 32'h0);
    chk("rst_stall", 32'(stall_out), 32'h0);
    chk("rst_err", 32'(err_out), 32'h0);

    // Directed cases
    do_access(1, 0, 3'b010, 32'h100, 32'h0, 5'd3, 0, 0, 32'hDEADBEEF);
    chk("lw_data", load_data_out, 32'hDEADBEEF);
    chk("lw_rd", 32'(rd_out), 32'd3);
    do_access(1, 0, 3'b000, 32'h103, 32'h0, 5'd4, 0, 1, 32'h80112233);
    chk("lb_data", load_data_out, 32'hFFFFFF80);
    do_access(1, 0, 3'b100, 32'h103, 32'h0, 5'd5, 1, 0, 32'h80112233);
    chk("lbu_data", load_data_out, 32'h00000080);
    do_access(0, 1, 3'b000, 32'h102, 32'h000000AB, 5'd6, 0, 0, 32'h0);
    chk("sb_keeps_load", load_data_out, 32'h00000080);
    chk("sb_keeps_rd", 32'(rd_out), 32'd5);
    do_access(0, 1, 3'b001, 32'h101, 32'h1234, 5'd7, 0, 0, 32'h0);
    do_access(1, 0, 3'b010, 32'h104, 32'h0, 5'd8, 3, 0, 32'h0BADF00D);
    do_access(1, 0, 3'b001, 32'h102, 32'h0, 5'd9, 0, 2, 32'h9ABC1234);
    chk("lh_data", load_data_out, 32'hFFFF9ABC);
    do_access(1, 0, 3'b101, 32'h102, 32'h0, 5'd10, 0, 0, 32'h9ABC1234);
    chk("lhu_data", load_data_out, 32'h00009ABC);
    do_access(0, 1, 3'b001, 32'h102, 32'h5678CDEF, 5'd11, 2, 0, 32'h0);
    do_access(0, 1, 3'b010, 32'h106, 32'h1, 5'd12, 0, 0, 32'h0);
    do_access(1, 0, 3'b011, 32'h100, 32'h0, 5'd13, 0, 0, 32'h0);
    do_access(1, 1, 3'b010, 32'h100, 32'h0, 5'd14, 0, 0, 32'h0);
    do_access(0, 1, 3'b100, 32'h100, 32'h0, 5'd15, 0, 0, 32'h0);

    // Reset while a load waits for its response; the late response is ignored
    @(negedge clk_in);
    mem_read_in = 1'b1;
    funct3_in = 3'b010;
    addr_in = 32'h200;
    rd_in = 5'd17;
    ready_cnt = 0;
    rsp_delay = 5;
    cur_rdata = 32'hCAFEF00D;
    orphan_rsp = 1'b1;
    req_q.push_back('{addr: 32'h200, we: 1'b0, be: 4'b1111, wdata: 32'h0});
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    mem_read_in = 1'b0;
    #1;
    chk("wait_stall", 32'(stall_out), 32'h1);
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    chk("rst_wait_stall", 32'(stall_out), 32'h0);
    chk("rst_wait_valid", 32'(bus.req_valid_out), 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      #1;
      chk("late_rsp_stall", 32'(stall_out), 32'h0);
    end
    chk("late_rsp_data", load_data_out, 32'h0);
    chk("late_rsp_pending", 32'(pending), 32'h0);
    orphan_rsp = 1'b0;

    // Reset while a store request is still waiting for ready
    @(negedge clk_in);
    mem_write_in = 1'b1;
    funct3_in = 3'b010;
    addr_in = 32'h300;
    wdata_in = 32'h11223344;
    ready_cnt = 10;
    req_q.push_back('{addr: 32'h300, we: 1'b1, be: 4'b1111, wdata: 32'h11223344});
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    mem_write_in = 1'b0;
    #1;
    chk("req_held", 32'(bus.req_valid_out), 32'h1);
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    chk("rst_req_drop", 32'(bus.req_valid_out), 32'h0);
    chk("rst_req_addr2", bus.req_addr_out, 32'h0);
    chk("rst_req_stall", 32'(stall_out), 32'h0);
    req_q.delete();

    // Randomized accesses
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(9);
      do_access(sel inside {[1:5], 9}, sel inside {[6:9]}, 3'($urandom_range(7)),
                {$urandom_range(32'hFFFF, 0), 16'h0} | 32'($urandom_range(15)),
                $urandom, 5'($urandom_range(31)), $urandom_range(3), $urandom_range(3), $urandom);
    end

    repeat (3) @(negedge clk_in);
    #1;
    chk("req_q_drained", 32'(req_q.size()), 32'h0);
    chk("rsp_q_drained", 32'(rsp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
